// File: rtl/uarc_send_receiver.sv
// uarc_send_receiver
// Receive-side front end for UARC send messages. Incoming sends are masked
// by per-bus interrupt enables, one requester is chosen, its data word is
// captured and acknowledged, and a single interrupt is held for the core
// until it is accepted (irq_ready) and serviced (irq_done).
//
// Build option: define UARC_RX_ROUND_ROBIN_EN for round-robin arbitration.
// With the macro undefined, arbitration is fixed priority (lowest index wins)
// and no round-robin pointer is built.
module uarc_send_receiver #(
    parameter int  WORD_MAG    = 5,
    parameter int  TOTAL_BUSES = 4,
    localparam int WORD_WIDTH  = 1 << WORD_MAG
) (
    input  logic                                   clk_i,
    input  logic                                   reset_ni,
    input  logic [TOTAL_BUSES-1:0]                 receiver_sends_i,
    input  logic [TOTAL_BUSES-1:0][WORD_WIDTH-1:0] receiver_datas_i,
    output logic [TOTAL_BUSES-1:0]                 receiver_send_acks_o,
    input  logic                                   enables_we_i,
    input  logic [TOTAL_BUSES-1:0]                 enables_wdata_i,
    output logic [TOTAL_BUSES-1:0]                 interrupt_enables_o,
    output logic                                   irq_valid_o,
    output logic [WORD_WIDTH-1:0]                  irq_bus_o,
    output logic [WORD_WIDTH-1:0]                  irq_data_o,
    input  logic                                   irq_ready_i,
    input  logic                                   irq_done_i,
    output logic [WORD_WIDTH-1:0]                  irq_count_o
);

    // Bus index width; a single bus still needs a one-bit index.
    localparam int IDX_W = (TOTAL_BUSES > 1) ? $clog2(TOTAL_BUSES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [TOTAL_BUSES-1:0] acks_q, acks_d;
    logic                   irq_valid_q, irq_valid_d;
    logic [WORD_WIDTH-1:0]  irq_bus_q, irq_bus_d;
    logic [WORD_WIDTH-1:0]  irq_data_q, irq_data_d;
    logic [WORD_WIDTH-1:0]  count_q, count_d;
    logic [TOTAL_BUSES-1:0] enables_q, enables_d;

    logic [TOTAL_BUSES-1:0] masked_s;
    logic [IDX_W-1:0]       cand_idx_s;
    logic [IDX_W-1:0]       grant_idx_s;
    logic                   grant_found_s;
    logic                   hit_s;

`ifdef UARC_RX_ROUND_ROBIN_EN
    // Index of the most recently granted bus; search starts one past it.
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
`endif

    assign masked_s = receiver_sends_i & enables_q;

    // Arbiter: scan candidates in priority order and keep the first masked hit.
    always_comb begin
        grant_idx_s   = '0;
        grant_found_s = 1'b0;
        cand_idx_s    = '0;
        hit_s         = 1'b0;
        for (int j = 0; j < TOTAL_BUSES; j++) begin
`ifdef UARC_RX_ROUND_ROBIN_EN
            cand_idx_s = IDX_W'((int'(rr_ptr_q) + 1 + j) % TOTAL_BUSES);
`else
            cand_idx_s = IDX_W'(j);
`endif
            hit_s         = ~grant_found_s & masked_s[cand_idx_s];
            grant_idx_s   = hit_s ? cand_idx_s : grant_idx_s;
            grant_found_s = grant_found_s | hit_s;
        end
    end

    // Next-state and registered-output logic for the capture/handshake FSM.
    always_comb begin
        state_d    = state_q;
        acks_d     = '0;
        irq_bus_d  = irq_bus_q;
        irq_data_d = irq_data_q;
        count_d    = count_q;
`ifdef UARC_RX_ROUND_ROBIN_EN
        rr_ptr_d   = rr_ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (grant_found_s) begin
                    state_d    = ST_PENDING;
                    acks_d     = TOTAL_BUSES'(1'b1) << grant_idx_s;
                    irq_bus_d  = WORD_WIDTH'(grant_idx_s);
                    irq_data_d = receiver_datas_i[grant_idx_s];
`ifdef UARC_RX_ROUND_ROBIN_EN
                    rr_ptr_d   = grant_idx_s;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PENDING: begin
                // irq_valid is high for the whole of PENDING.
                if (irq_ready_i) begin
                    state_d = ST_SERVICE;
                    count_d = count_q + WORD_WIDTH'(1);
                end else begin
                    state_d = ST_PENDING;
                end
            end
            ST_SERVICE: begin
                if (irq_done_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SERVICE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        irq_valid_d = (state_d == ST_PENDING);
    end

    // Enable mask next value: a write replaces the whole mask.
    always_comb begin
        if (enables_we_i) begin
            enables_d = enables_wdata_i;
        end else begin
            enables_d = enables_q;
        end
    end

    // FSM state and captured interrupt registers.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= ST_IDLE;
            acks_q      <= '0;
            irq_valid_q <= 1'b0;
            irq_bus_q   <= '0;
            irq_data_q  <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            acks_q      <= acks_d;
            irq_valid_q <= irq_valid_d;
            irq_bus_q   <= irq_bus_d;
            irq_data_q  <= irq_data_d;
            count_q     <= count_d;
        end
    end

    // Interrupt enable mask register.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            enables_q <= '0;
        end else begin
            enables_q <= enables_d;
        end
    end

`ifdef UARC_RX_ROUND_ROBIN_EN
    // Round-robin pointer; resetting to the last bus gives bus 0 first turn.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rr_ptr_q <= IDX_W'(TOTAL_BUSES - 1);
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    assign receiver_send_acks_o = acks_q;
    assign interrupt_enables_o  = enables_q;
    assign irq_valid_o          = irq_valid_q;
    assign irq_bus_o            = irq_bus_q;
    assign irq_data_o           = irq_data_q;
    assign irq_count_o          = count_q;

endmodule

// File: tb/tb_uarc_send_receiver.sv
// Directed self-checking bench for uarc_send_receiver: a 4-bus 32-bit
// instance for the main behaviour and a 1-bus 8-bit instance for the
// counter wrap and single-bus index.
module tb_uarc_send_receiver;

    logic              clk;
    logic              reset_n;

    // Main instance: WORD_MAG=5, TOTAL_BUSES=4
    logic [3:0]        sends;
    logic [3:0][31:0]  datas;
    logic [3:0]        acks;
    logic              en_we;
    logic [3:0]        en_wdata;
    logic [3:0]        enables;
    logic              irq_valid;
    logic [31:0]       irq_bus;
    logic [31:0]       irq_data;
    logic              irq_ready;
    logic              irq_done;
    logic [31:0]       irq_count;

    // Small instance: WORD_MAG=3, TOTAL_BUSES=1
    logic [0:0]        d1_send;
    logic [0:0][7:0]   d1_data;
    logic [0:0]        d1_ack;
    logic              d1_we;
    logic [0:0]        d1_wdata;
    logic [0:0]        d1_en;
    logic              d1_valid;
    logic [7:0]        d1_bus;
    logic [7:0]        d1_irq_data;
    logic              d1_ready;
    logic              d1_done;
    logic [7:0]        d1_count;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_count;
    logic [1:0] exp_seq [4];

    uarc_send_receiver #(.WORD_MAG(5), .TOTAL_BUSES(4)) dut (
        .clk_i                (clk),
        .reset_ni             (reset_n),
        .receiver_sends_i     (sends),
        .receiver_datas_i     (datas),
        .receiver_send_acks_o (acks),
        .enables_we_i         (en_we),
        .enables_wdata_i      (en_wdata),
        .interrupt_enables_o  (enables),
        .irq_valid_o          (irq_valid),
        .irq_bus_o            (irq_bus),
        .irq_data_o           (irq_data),
        .irq_ready_i          (irq_ready),
        .irq_done_i           (irq_done),
        .irq_count_o          (irq_count)
    );

    uarc_send_receiver #(.WORD_MAG(3), .TOTAL_BUSES(1)) dut1 (
        .clk_i                (clk),
        .reset_ni             (reset_n),
        .receiver_sends_i     (d1_send),
        .receiver_datas_i     (d1_data),
        .receiver_send_acks_o (d1_ack),
        .enables_we_i         (d1_we),
        .enables_wdata_i      (d1_wdata),
        .interrupt_enables_o  (d1_en),
        .irq_valid_o          (d1_valid),
        .irq_bus_o            (d1_bus),
        .irq_data_o           (d1_irq_data),
        .irq_ready_i          (d1_ready),
        .irq_done_i           (d1_done),
        .irq_count_o          (d1_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; sample and drive 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_enables(input logic [3:0] mask);
        en_we    = 1'b1;
        en_wdata = mask;
        tick();
        en_we    = 1'b0;
    endtask

    // Core accepts the pending interrupt, then finishes it; ends in IDLE.
    task automatic finish_irq();
        irq_ready = 1'b1;
        tick();
        irq_ready = 1'b0;
        irq_done  = 1'b1;
        tick();
        irq_done  = 1'b0;
    endtask

    initial begin
        sends = 4'b0000; datas = '0; en_we = 1'b0; en_wdata = 4'b0000;
        irq_ready = 1'b0; irq_done = 1'b0;
        d1_send = 1'b0; d1_data = '0; d1_we = 1'b0; d1_wdata = 1'b0;
        d1_ready = 1'b0; d1_done = 1'b0;
        exp_count = 0;
        reset_n = 1'b1;
        #2;
        reset_n = 1'b0;
        tick();

        // Reset values
        check("rst_acks",    {28'd0, acks},      32'd0);
        check("rst_valid",   {31'd0, irq_valid}, 32'd0);
        check("rst_bus",     irq_bus,            32'd0);
        check("rst_data",    irq_data,           32'd0);
        check("rst_enables", {28'd0, enables},   32'd0);
        check("rst_count",   irq_count,          32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // Arbitration: buses 0 and 3 enabled and sending continuously
`ifdef UARC_RX_ROUND_ROBIN_EN
        exp_seq[0] = 2'd0; exp_seq[1] = 2'd3; exp_seq[2] = 2'd0; exp_seq[3] = 2'd3;
`else
        exp_seq[0] = 2'd0; exp_seq[1] = 2'd0; exp_seq[2] = 2'd0; exp_seq[3] = 2'd0;
`endif
        set_enables(4'b1001);
        datas[0] = 32'h0000_00A0;
        datas[3] = 32'h0000_00A3;
        sends    = 4'b1001;
        for (int g = 0; g < 4; g++) begin
            tick();
            check("arb_ack",  {28'd0, acks},  {28'd0, 4'b0001 << exp_seq[g]});
            check("arb_bus",  irq_bus,        {30'd0, exp_seq[g]});
            check("arb_data", irq_data,       {24'd0, 4'hA, 2'b00, exp_seq[g]});
            finish_irq();
            exp_count++;
        end
        sends = 4'b0000;
        check("arb_count", irq_count, exp_count);

        // Basic capture on bus 2
        set_enables(4'b0100);
        datas[2] = 32'hDEAD_BEEF;
        sends    = 4'b0100;
        check("basic_ack_before", {28'd0, acks}, 32'd0);
        tick();
        check("basic_ack",   {28'd0, acks},      32'h4);
        check("basic_valid", {31'd0, irq_valid}, 32'd1);
        check("basic_bus",   irq_bus,            32'd2);
        check("basic_data",  irq_data,           32'hDEAD_BEEF);
        sends = 4'b0000;
        tick();
        check("basic_ack_one_cycle", {28'd0, acks},      32'd0);
        check("basic_valid_held",    {31'd0, irq_valid}, 32'd1);
        irq_ready = 1'b1;
        tick();
        irq_ready = 1'b0;
        exp_count++;
        check("basic_pending_one_cycle", {31'd0, irq_valid}, 32'd0);
        check("basic_count", irq_count, exp_count);
        tick();
        check("basic_service_valid", {31'd0, irq_valid}, 32'd0);
        irq_done = 1'b1;
        tick();
        irq_done = 1'b0;

        // Masking: disabled bus is ignored until its enable is written
        set_enables(4'b0000);
        datas[1] = 32'h1111_1111;
        sends    = 4'b0010;
        tick();
        tick();
        tick();
        check("mask_no_ack",   {28'd0, acks},      32'd0);
        check("mask_no_valid", {31'd0, irq_valid}, 32'd0);
        en_we    = 1'b1;
        en_wdata = 4'b0010;
        tick();
        en_we    = 1'b0;
        check("mask_ack_not_yet", {28'd0, acks}, 32'd0);
        tick();
        check("mask_ack",  {28'd0, acks}, 32'h2);
        check("mask_bus",  irq_bus,       32'd1);
        check("mask_data", irq_data,      32'h1111_1111);
        sends = 4'b0000;
        finish_irq();
        exp_count++;

        // Blocking: bus 1 sends during PENDING and SERVICE
        set_enables(4'b0011);
        datas[0] = 32'hAAAA_0000;
        datas[1] = 32'hBBBB_1111;
        sends    = 4'b0001;
        tick();
        check("blk_ack0", {28'd0, acks}, 32'h1);
        sends = 4'b0010;
        tick();
        check("blk_pending_no_ack", {28'd0, acks}, 32'd0);
        check("blk_pending_bus",    irq_bus,       32'd0);
        irq_ready = 1'b1;
        tick();
        irq_ready = 1'b0;
        exp_count++;
        check("blk_service_no_ack", {28'd0, acks}, 32'd0);
        tick();
        check("blk_service_no_ack2", {28'd0, acks}, 32'd0);
        irq_done = 1'b1;
        tick();
        irq_done = 1'b0;
        check("blk_idle_no_ack", {28'd0, acks}, 32'd0);
        tick();
        check("blk_ack1",  {28'd0, acks}, 32'h2);
        check("blk_bus1",  irq_bus,       32'd1);
        check("blk_data1", irq_data,      32'hBBBB_1111);
        sends = 4'b0000;
        finish_irq();
        exp_count++;
        check("blk_count", irq_count, exp_count);

        // Enable write in the capture cycle: old mask applies, capture stands
        en_we    = 1'b1;
        en_wdata = 4'b0000;
        sends    = 4'b0001;
        tick();
        en_we = 1'b0;
        sends = 4'b0000;
        check("we_same_cycle_ack",     {28'd0, acks},    32'h1);
        check("we_same_cycle_enables", {28'd0, enables}, 32'd0);
        tick();
        check("we_not_cancelled", {31'd0, irq_valid}, 32'd1);
        finish_irq();
        exp_count++;
        check("we_count", irq_count, exp_count);

        // Reset asserted while PENDING
        set_enables(4'b0010);
        sends = 4'b0010;
        tick();
        check("rstp_valid_before", {31'd0, irq_valid}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("rstp_valid",   {31'd0, irq_valid}, 32'd0);
        check("rstp_ack",     {28'd0, acks},      32'd0);
        check("rstp_enables", {28'd0, enables},   32'd0);
        check("rstp_count",   irq_count,          32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        tick();
        check("rstp_no_recapture",  {28'd0, acks},      32'd0);
        check("rstp_no_valid",      {31'd0, irq_valid}, 32'd0);
        set_enables(4'b0010);
        tick();
        check("rstp_recapture_ack", {28'd0, acks},      32'h2);
        sends = 4'b0000;
        finish_irq();

        // Single-bus, 8-bit instance: index always 0 and counter wraps
        d1_we    = 1'b1;
        d1_wdata = 1'b1;
        tick();
        d1_we      = 1'b0;
        d1_send    = 1'b1;
        d1_data[0] = 8'hA5;
        for (int i = 0; i < 256; i++) begin
            tick();
            if (i == 0) begin
                check("d1_ack",  {31'd0, d1_ack},     32'd1);
                check("d1_bus",  {24'd0, d1_bus},     32'd0);
                check("d1_data", {24'd0, d1_irq_data}, 32'hA5);
            end
            d1_ready = 1'b1;
            tick();
            d1_ready = 1'b0;
            d1_done  = 1'b1;
            tick();
            d1_done  = 1'b0;
            if (i == 254) begin
                check("d1_count_255", {24'd0, d1_count}, 32'd255);
            end
        end
        d1_send = 1'b0;
        check("d1_count_wrap", {24'd0, d1_count}, 32'd0);
        check("d1_bus_end",    {24'd0, d1_bus},   32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uarc_send_receiver.md
# uarc_send_receiver

Receive-side front end for UARC `send` messages on the core. It masks incoming sends with per-bus interrupt enables and selects one requesting bus. It captures that bus's data word, acknowledges the sender, and holds a single interrupt request for the core until the core accepts it and signals the end of service. It generalises the core's combinational masked-send priority chooser: the bus count and word width are parametrised, capture is registered, the sender handshake is closed, and round-robin arbitration is an optional mode.

## Interface
- WORD_MAG, 5: log2 of word width; WORD_WIDTH = 1 << WORD_MAG.
- TOTAL_BUSES, 4: number of receiver buses; legal range 1 ≤ TOTAL_BUSES ≤ 2**WORD_WIDTH.
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset; asserting it (low) forces reset values immediately.
- receiver_sends  in  TOTAL_BUSES  per-bus send request; sender holds it and its data stable until acked.
- receiver_datas  in  TOTAL_BUSES×WORD_WIDTH  per-bus send data.
- receiver_send_acks  out  TOTAL_BUSES  one-cycle registered ack to the captured bus.
- enables_we  in  1  write strobe for interrupt enables.
- enables_wdata  in  TOTAL_BUSES  new enable mask.
- interrupt_enables  out  TOTAL_BUSES  current enable mask.
- irq_valid  out  1  captured message pending for core.
- irq_bus  out  WORD_WIDTH  captured bus index, zero-extended.
- irq_data  out  WORD_WIDTH  captured data word.
- irq_ready  in  1  core takes the interrupt.
- irq_done  in  1  core finished the interrupt handler.
- irq_count  out  WORD_WIDTH  number of interrupts accepted by the core; wraps modulo 2**WORD_WIDTH.

## Operation
- masked[i] = receiver_sends[i] & interrupt_enables[i]. Enables are registered; a write is visible to masking from the cycle after the `enables_we` edge.
- The FSM has three states: IDLE, PENDING, SERVICE.
- **IDLE → PENDING:** taken when any masked bit is set. At that edge:
  - bus k is chosen by the arbiter;
  - `irq_bus` ← k and `irq_data` ← receiver_datas[k];
  - receiver_send_acks[k] ← 1 for exactly one cycle.
- **PENDING:** `irq_valid` = 1. Sends are ignored, so no second ack is issued. On `irq_valid & irq_ready` the FSM moves to SERVICE and `irq_count` increments.
- **SERVICE:** `irq_valid` = 0 and sends are ignored. `irq_done` returns the FSM to IDLE.
- `irq_done` is ignored outside SERVICE, and `irq_ready` is ignored outside PENDING.
- Clearing the enable bit of an already captured bus does not cancel the pending interrupt.
- Arbitration is fixed priority (lowest index wins) unless round-robin is configured; see Configuration.
- Reset values:
  - state IDLE;
  - all acks 0;
  - `irq_valid` 0, `irq_bus` 0, `irq_data` 0;
  - `interrupt_enables` 0;
  - `irq_count` 0;
  - round-robin pointer TOTAL_BUSES-1.

## Timing
- Capture latency: a masked send present in IDLE during cycle N gives ack and `irq_valid` high in cycle N+1.
- The sender must deassert send by the edge ending cycle N+1. A send still high when the FSM next returns to IDLE is treated as a new message.
- Earliest re-capture after `irq_done` in cycle M: ack in cycle M+2, because the FSM is in IDLE during M+1.
- `enables_we` in the same cycle as a capture: the capture uses the old mask.
- If `irq_ready` stays high, PENDING lasts exactly one cycle.
- Reset asserted mid-operation drops any pending interrupt and ack at once. A sender still holding send is recaptured only after reset is released and enables are rewritten.
- TOTAL_BUSES = 1: the arbiter degenerates to bus 0, and `irq_bus` is always 0.

## Configuration
- UARC_RX_ROUND_ROBIN_EN defined: the search starts at (pointer+1) mod TOTAL_BUSES, and the pointer ← k on each capture. Bus 0 has first priority after reset.
- UARC_RX_ROUND_ROBIN_EN undefined: fixed lowest-index priority. The pointer logic is not built.

## Test plan
- **Basic capture.** Enables=4'b0100; bus 2 sends 0xDEADBEEF in cycle 5. Expect:
  - ack[2] high in cycle 6 only;
  - `irq_valid`=1, `irq_bus`=2, `irq_data`=0xDEADBEEF;
  - `irq_ready` → SERVICE and `irq_count`=1;
  - `irq_done` → IDLE.
- **Masking.** Enables=0; bus 1 sends. Expect no ack and no `irq_valid`. Write enables=4'b0010 and expect ack[1] on the second cycle after the write.
- **Arbitration.** Buses 0 and 3 both enabled and sending continuously, each handled to done. Expect:
  - fixed priority: bus 0 only after the first grant re-arms;
  - with UARC_RX_ROUND_ROBIN_EN: grant order 0, 3, 0, 3.
- **Blocking.** Bus 1 sends while in PENDING and while in SERVICE. Expect no ack until `irq_done`, then ack[1] two cycles later.
- **Reset mid-PENDING.** Drive reset low while in PENDING. Expect immediately:
  - `irq_valid`=0;
  - `interrupt_enables`=0;
  - `irq_count`=0.

  After release, expect no capture while the send is still held.
- **Counter wrap.** WORD_MAG=3 with 256 accepted interrupts. Expect `irq_count` to wrap from 255 to 0.
